// File: rtl/regfiles_mp_if.sv
// Bus bundle for regfiles_mp: read ports, two write ports, scoreboard set.
// Master drives addresses/writes/sets; slave returns read data and busy bits.
interface regfiles_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] addr_rd;
    logic [NUM_RD*DATA_W-1:0] data_rd;
    logic [NUM_RD-1:0]        busy_rd;
    logic                     wren0;
    logic [ADDR_W-1:0]        addr_w0;
    logic [DATA_W-1:0]        data_w0;
    logic                     wren1;
    logic [ADDR_W-1:0]        addr_w1;
    logic [DATA_W-1:0]        data_w1;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;

    modport master (
        output addr_rd, wren0, addr_w0, data_w0,
        output wren1, addr_w1, data_w1, sb_set, sb_addr,
        input  data_rd, busy_rd
    );

    modport slave (
        input  addr_rd, wren0, addr_w0, data_w0,
        input  wren1, addr_w1, data_w1, sb_set, sb_addr,
        output data_rd, busy_rd
    );
endinterface

// File: rtl/regfiles_mp.sv
// Multi-port register file with hardwired r0 and pending-write scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfiles_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input logic          clk,
    input logic          aclr,
    regfiles_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr0_ok;
    logic              wr1_ok;

    assign wr0_ok = bus.wren0 && (bus.addr_w0 != '0);
    assign wr1_ok = bus.wren1 && (bus.addr_w1 != '0);

    // Next state: port 1 lands after port 0 so it wins; set lands after clears
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr0_ok) regs_d[bus.addr_w0] = bus.data_w0;
        if (wr1_ok) regs_d[bus.addr_w1] = bus.data_w1;
        if (bus.wren0) busy_d[bus.addr_w0] = 1'b0;
        if (bus.wren1) busy_d[bus.addr_w1] = 1'b0;
        if (bus.sb_set) busy_d[bus.sb_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State registers; reset clears storage and scoreboard over any update
    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = bus.addr_rd[k*ADDR_W +: ADDR_W];

        // Read mux; r0 forced to zero even before the first reset
        always_comb begin
            rd = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (bus.wren0 && (bus.addr_w0 == ra)) rd = bus.data_w0;
            if (bus.wren1 && (bus.addr_w1 == ra)) rd = bus.data_w1;
`endif
            if (ra == '0) rd = '0;
        end

        assign bus.data_rd[k*DATA_W +: DATA_W] = rd;
        assign bus.busy_rd[k] = (ra != '0) && busy_q[ra];
    end
endmodule

// File: tb/tb_regfiles_mp.sv
// Directed scoreboard bench for regfiles_mp (2-port and 4-port builds).
// Expected values are queued at drive time and popped at each check.
module tb_regfiles_mp;
    logic clk = 1'b0;
    logic aclr;

    always #5 clk = ~clk;

    regfiles_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus2 ();
    regfiles_mp_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4)) bus4 ();

    regfiles_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut2 (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus2.slave)
    );

    regfiles_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4)) dut4 (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus4.slave)
    );

    typedef struct {
        string        tag;
        logic [127:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [127:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [127:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h required queued entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle2();
        bus2.wren0 = 1'b0;
        bus2.addr_w0 = '0;
        bus2.data_w0 = '0;
        bus2.wren1 = 1'b0;
        bus2.addr_w1 = '0;
        bus2.data_w1 = '0;
        bus2.sb_set = 1'b0;
        bus2.sb_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] v4(input int a);
        return 32'h5A00_0000 | (32'(a) << 8) | 32'(a);
    endfunction

    logic [31:0]  bypv;
    logic [127:0] pk;
    int           a;

    initial begin
        idle2();
        bus2.addr_rd = '0;
        bus4.addr_rd = '0;
        bus4.wren0 = 1'b0;
        bus4.addr_w0 = '0;
        bus4.data_w0 = '0;
        bus4.wren1 = 1'b0;
        bus4.addr_w1 = '0;
        bus4.data_w1 = '0;
        bus4.sb_set = 1'b0;
        bus4.sb_addr = '0;
        aclr = 1'b1;
        tick();
        aclr = 1'b0;

        bus2.addr_rd = {5'd9, 5'd5};
        #1;
        push("rst_data", 128'd0);
        chk(128'(bus2.data_rd));
        push("rst_busy", 128'd0);
        chk(128'(bus2.busy_rd));

        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd0;
        bus2.data_w0 = 32'hF0F0_F0F0;
        bus2.sb_set = 1'b1;
        bus2.sb_addr = 5'd0;
        bus2.addr_rd = {5'd0, 5'd0};
        tick();
        idle2();
        #1;
        push("r0_data", 128'd0);
        chk(128'(bus2.data_rd));
        push("r0_busy", 128'd0);
        chk(128'(bus2.busy_rd));

        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd1;
        bus2.data_w0 = 32'h1234_5678;
        bus2.wren1 = 1'b1;
        bus2.addr_w1 = 5'd1;
        bus2.data_w1 = 32'hDEAD_BEEF;
        tick();
        idle2();
        bus2.addr_rd = {5'd1, 5'd1};
        #1;
        push("wr_prio", {64'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        chk(128'(bus2.data_rd));

        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd3;
        bus2.data_w0 = 32'hA5A5_A5A5;
        bus2.addr_rd = {5'd3, 5'd3};
`ifdef REGFILE_BYPASS_EN
        bypv = 32'hA5A5_A5A5;
`else
        bypv = 32'h0;
`endif
        #1;
        push("same_cyc_rd", {64'd0, bypv, bypv});
        chk(128'(bus2.data_rd));
        tick();
        idle2();
        #1;
        push("next_cyc_rd", {64'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5});
        chk(128'(bus2.data_rd));

        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd4;
        bus2.data_w0 = 32'h1111_1111;
        bus2.wren1 = 1'b1;
        bus2.addr_w1 = 5'd4;
        bus2.data_w1 = 32'h2222_2222;
        bus2.addr_rd = {5'd4, 5'd1};
`ifdef REGFILE_BYPASS_EN
        bypv = 32'h2222_2222;
`else
        bypv = 32'h0;
`endif
        #1;
        push("byp_prio", {64'd0, bypv, 32'hDEAD_BEEF});
        chk(128'(bus2.data_rd));
        tick();
        idle2();

        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd8;
        bus2.data_w0 = 32'h0000_8888;
        bus2.wren1 = 1'b1;
        bus2.addr_w1 = 5'd9;
        bus2.data_w1 = 32'h0000_9999;
        tick();
        idle2();
        bus2.addr_rd = {5'd9, 5'd8};
        #1;
        push("dual_commit", {64'd0, 32'h0000_9999, 32'h0000_8888});
        chk(128'(bus2.data_rd));

        bus2.sb_set = 1'b1;
        bus2.sb_addr = 5'd5;
        bus2.addr_rd = {5'd0, 5'd5};
        #1;
        push("sb_pre_edge", 128'd0);
        chk(128'(bus2.busy_rd));
        tick();
        idle2();
        #1;
        push("sb_set", 128'd1);
        chk(128'(bus2.busy_rd));

        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd5;
        bus2.data_w0 = 32'h0000_0055;
        tick();
        idle2();
        #1;
        push("sb_clear", 128'd0);
        chk(128'(bus2.busy_rd));
        push("sb_clear_data", {96'd0, 32'h0000_0055});
        chk(128'(bus2.data_rd));

        bus2.sb_set = 1'b1;
        bus2.sb_addr = 5'd5;
        bus2.wren1 = 1'b1;
        bus2.addr_w1 = 5'd5;
        bus2.data_w1 = 32'h0000_0056;
        tick();
        idle2();
        #1;
        push("sb_set_wins", 128'd1);
        chk(128'(bus2.busy_rd));

        for (int i = 1; i < 32; i += 2) begin
            bus2.wren0 = 1'b1;
            bus2.addr_w0 = 5'(i);
            bus2.data_w0 = 32'(i);
            bus2.wren1 = (i < 31);
            bus2.addr_w1 = 5'(i + 1);
            bus2.data_w1 = 32'(i + 1);
            tick();
        end
        idle2();
        bus2.addr_rd = {5'd31, 5'd7};
        #1;
        push("fill", {64'd0, 32'd31, 32'd7});
        chk(128'(bus2.data_rd));

        aclr = 1'b1;
        bus2.wren0 = 1'b1;
        bus2.addr_w0 = 5'd7;
        bus2.data_w0 = 32'hFFFF_FFFF;
        bus2.sb_set = 1'b1;
        bus2.sb_addr = 5'd7;
        tick();
        aclr = 1'b0;
        idle2();
        for (int i = 0; i < 32; i++) begin
            bus2.addr_rd = {5'(31 - i), 5'(i)};
            #1;
            push($sformatf("clr_data_r%0d", i), 128'd0);
            chk(128'(bus2.data_rd));
            push($sformatf("clr_busy_r%0d", i), 128'd0);
            chk(128'(bus2.busy_rd));
        end

        for (int i = 1; i < 16; i++) begin
            bus4.wren0 = 1'b1;
            bus4.addr_w0 = 4'(i);
            bus4.data_w0 = v4(i);
            tick();
        end
        bus4.wren0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pk = '0;
            for (int k = 0; k < 4; k++) begin
                a = ((c * 4 + k) % 15) + 1;
                bus4.addr_rd[k*4 +: 4] = 4'(a);
                pk[k*32 +: 32] = v4(a);
            end
            #1;
            push($sformatf("p4_rd_c%0d", c), pk);
            chk(bus4.data_rd);
            push($sformatf("p4_busy_c%0d", c), 128'd0);
            chk(128'(bus4.busy_rd));
            tick();
        end

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_leftover: observed %0d entries required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
